// File: rtl/clock_burst_ctrl_if.sv
// Configuration handshake and roll-over output bundle of the burst sequencer.
// The controller takes the slave side; whoever programs it takes the master side.
interface clock_burst_ctrl_if #(
   parameter int W_DIV = 16,
   parameter int W_CNT = 8
);
   logic             i_cfg_valid;
   logic             o_cfg_ready;
   logic [W_DIV-1:0] i_cfg_div;
   logic [W_CNT-1:0] i_cfg_count;
   logic             i_stop;
   logic             o_roll_over;
   logic             o_busy;
   logic             o_done;
   logic [W_CNT-1:0] o_pulses;

   modport master (
      output i_cfg_valid, i_cfg_div, i_cfg_count, i_stop,
      input  o_cfg_ready, o_roll_over, o_busy, o_done, o_pulses
   );

   modport slave (
      input  i_cfg_valid, i_cfg_div, i_cfg_count, i_stop,
      output o_cfg_ready, o_roll_over, o_busy, o_done, o_pulses
   );
endinterface

// File: rtl/clock_burst_ctrl.sv
// Roll-over pulse sequencer for the toggle-clock block: fixed-length or free-running
// bursts of one-cycle pulses every d_eff cycles, programmed over a valid/ready handshake.
module clock_burst_ctrl #(
   parameter int W_DIV = 16,
   parameter int W_CNT = 8
) (
   input logic               i_clk,
   input logic               i_reset,
   clock_burst_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [W_DIV-1:0] d_eff;
      logic [W_CNT-1:0] n;
   } cfg_t;

   state_t           state, state_nxt;
   cfg_t             cfg, cfg_nxt;
   logic [W_DIV-1:0] presc, presc_nxt;
   logic [W_CNT-1:0] pulses, pulses_nxt;
   logic             roll, roll_nxt;
   logic             wrap;

   // Pulse rises on the edge where the prescaler leaves d_eff-1.
   assign wrap = (presc == cfg.d_eff - W_DIV'(1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= IDLE;
         cfg    <= '0;
         presc  <= '0;
         pulses <= '0;
         roll   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cfg    <= cfg_nxt;
         presc  <= presc_nxt;
         pulses <= pulses_nxt;
         roll   <= roll_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cfg_nxt    = cfg;
      presc_nxt  = presc;
      pulses_nxt = pulses;
      roll_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_cfg_valid) begin
               state_nxt     = RUN;
               // Clamp to 2 so the output always has a low cycle between pulses.
               cfg_nxt.d_eff = (bus.i_cfg_div < W_DIV'(2)) ? W_DIV'(2) : bus.i_cfg_div;
               cfg_nxt.n     = bus.i_cfg_count;
               presc_nxt     = '0;
               pulses_nxt    = '0;
            end
         end
         RUN: begin
            if (bus.i_stop) begin
               state_nxt = IDLE;
            end else if (roll && cfg.n != '0 && pulses == cfg.n) begin
               state_nxt = DONE;
            end else begin
               presc_nxt = wrap ? '0 : presc + W_DIV'(1);
               if (wrap) begin
                  roll_nxt   = 1'b1;
                  pulses_nxt = pulses + W_CNT'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.o_cfg_ready = (state == IDLE);
   assign bus.o_busy      = (state != IDLE);
   assign bus.o_done      = (state == DONE);
   assign bus.o_roll_over = roll;
   assign bus.o_pulses    = pulses;
endmodule
